// File: rtl/pkmc_sdram_initseq.sv
// SDRAM power-up initialisation sequencer: power-up wait, PRECHARGE ALL, NUM_REF AUTO REFRESH, mode load.
// Define PKMC_SDRAM_INIT_EMRS_EN to insert an extended-mode-register load before the mode load.
module pkmc_sdram_initseq #(
  parameter int CNT_W     = 16,
  parameter int PWRUP_CYC = 10000,
  parameter int TRP_CYC   = 2,
  parameter int TRFC_CYC  = 7,
  parameter int TMRD_CYC  = 2,
  parameter int NUM_REF   = 8,
  parameter int REF_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart_i,
  output logic [2:0]       cmd_o,
  output logic             cmd_valid_o,
  input  logic             cmd_ack_i,
  output logic             busy_o,
  output logic             init_done_o,
  output logic [REF_W-1:0] ref_cnt_o
);

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_PRE   = 3'd1;
  localparam logic [2:0] CMD_REF   = 3'd2;
  localparam logic [2:0] CMD_MRS   = 3'd3;
`ifdef PKMC_SDRAM_INIT_EMRS_EN
  localparam logic [2:0] CMD_EMRS  = 3'd4;
`endif

  localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0] TRP_LD   = CNT_W'(TRP_CYC - 1);
  localparam logic [CNT_W-1:0] TRFC_LD  = CNT_W'(TRFC_CYC - 1);
  localparam logic [CNT_W-1:0] TMRD_LD  = CNT_W'(TMRD_CYC - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(NUM_REF);

  typedef enum logic [3:0] {
    S_PWRUP,
    S_PRE,
    S_PRE_W,
    S_REF,
    S_REF_W,
`ifdef PKMC_SDRAM_INIT_EMRS_EN
    S_EMRS,
    S_EMRS_W,
`endif
    S_MRS,
    S_MRS_W,
    S_DONE
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [REF_W-1:0] ref_cnt, ref_d;
  logic             init_done, done_d;
  logic             cnt_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_PWRUP;
      cnt       <= PWRUP_LD;
      ref_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      ref_cnt   <= ref_d;
      init_done <= done_d;
    end
  end

  assign cnt_zero = (cnt == '0);

  // Wait states leave on the edge where the counter is already zero, so a load of T-1 gives T cycles.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    ref_d       = ref_cnt;
    done_d      = init_done;
    cmd_o       = CMD_NOP;
    cmd_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state)
      S_PWRUP: begin
        if (cnt_zero) state_d = S_PRE;
        else          cnt_d   = cnt - CNT_W'(1);
      end
      S_PRE: begin
        cmd_o       = CMD_PRE;
        cmd_valid_o = 1'b1;
        if (cmd_ack_i) begin
          state_d = S_PRE_W;
          cnt_d   = TRP_LD;
        end
      end
      S_PRE_W: begin
        if (cnt_zero) state_d = S_REF;
        else          cnt_d   = cnt - CNT_W'(1);
      end
      S_REF: begin
        cmd_o       = CMD_REF;
        cmd_valid_o = 1'b1;
        if (cmd_ack_i) begin
          state_d = S_REF_W;
          cnt_d   = TRFC_LD;
          ref_d   = ref_cnt + REF_W'(1);
        end
      end
      S_REF_W: begin
        if (!cnt_zero) begin
          cnt_d = cnt - CNT_W'(1);
        end else if (ref_cnt == REF_LAST) begin
`ifdef PKMC_SDRAM_INIT_EMRS_EN
          state_d = S_EMRS;
`else
          state_d = S_MRS;
`endif
        end else begin
          state_d = S_REF;
        end
      end
`ifdef PKMC_SDRAM_INIT_EMRS_EN
      S_EMRS: begin
        cmd_o       = CMD_EMRS;
        cmd_valid_o = 1'b1;
        if (cmd_ack_i) begin
          state_d = S_EMRS_W;
          cnt_d   = TMRD_LD;
        end
      end
      S_EMRS_W: begin
        if (cnt_zero) state_d = S_MRS;
        else          cnt_d   = cnt - CNT_W'(1);
      end
`endif
      S_MRS: begin
        cmd_o       = CMD_MRS;
        cmd_valid_o = 1'b1;
        if (cmd_ack_i) begin
          state_d = S_MRS_W;
          cnt_d   = TMRD_LD;
        end
      end
      S_MRS_W: begin
        if (cnt_zero) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        busy_o = 1'b0;
        if (restart_i) begin
          state_d = S_PRE;
          done_d  = 1'b0;
          ref_d   = '0;
        end
      end
      default: state_d = S_PWRUP;
    endcase
  end

  assign init_done_o = init_done;
  assign ref_cnt_o   = ref_cnt;

endmodule

// File: tb/tb_pkmc_sdram_initseq.sv
// Scoreboard bench for pkmc_sdram_initseq: expected command timeline queued per run, checked by a negedge monitor.
// Honours PKMC_SDRAM_INIT_EMRS_EN the same way as the design.
module tb_pkmc_sdram_initseq;

  localparam int CNT_W = 16;
  localparam int PWRUP = 10000;
  localparam int TRP   = 2;
  localparam int TRFC  = 7;
  localparam int TMRD  = 2;
  localparam int NREF  = 8;
  localparam int REF_W = 4;
  localparam int unsigned DONE_CODE = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             restart_i = 1'b0;
  logic             cmd_ack_i = 1'b0;
  logic [2:0]       cmd_o;
  logic             cmd_valid_o;
  logic             busy_o;
  logic             init_done_o;
  logic [REF_W-1:0] ref_cnt_o;

  always #5 clk = ~clk;

  pkmc_sdram_initseq #(
    .CNT_W(CNT_W), .PWRUP_CYC(PWRUP), .TRP_CYC(TRP), .TRFC_CYC(TRFC),
    .TMRD_CYC(TMRD), .NUM_REF(NREF), .REF_W(REF_W)
  ) dut (
    .clk(clk), .rst(rst), .restart_i(restart_i),
    .cmd_o(cmd_o), .cmd_valid_o(cmd_valid_o), .cmd_ack_i(cmd_ack_i),
    .busy_o(busy_o), .init_done_o(init_done_o), .ref_cnt_o(ref_cnt_o)
  );

  typedef struct {
    int unsigned code;   // command code, or DONE_CODE for the init_done rise
    int unsigned gap;    // samples since the last anchor (reset release, restart, ack)
    int unsigned refc;   // ref_cnt_o expected at that moment
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   ack_rand = 1'b0;
  int   stall_left = 0;

  function automatic exp_t mk(input int unsigned c, input int unsigned g, input int unsigned r);
    exp_t e;
    e.code = c;
    e.gap  = g;
    e.refc = r;
    return e;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One full run: each command rises T+1 samples after the previous ack.
  task automatic push_run(input int unsigned gap0);
    q.push_back(mk(1, gap0, 0));
    for (int unsigned i = 0; i < NREF; i++)
      q.push_back(mk(2, (i == 0) ? TRP + 1 : TRFC + 1, i));
`ifdef PKMC_SDRAM_INIT_EMRS_EN
    q.push_back(mk(4, TRFC + 1, NREF));
    q.push_back(mk(3, TMRD + 1, NREF));
`else
    q.push_back(mk(3, TRFC + 1, NREF));
`endif
    q.push_back(mk(DONE_CODE, TMRD + 1, NREF));
  endtask

  // Monitor
  int unsigned scyc = 0, anchor = 0;
  bit          pv = 0, pd = 0, pstall = 0, mdl_done = 0;
  logic [2:0]  pcmd = '0;

  always @(negedge clk) begin
    exp_t e;
    scyc++;
    if (rst) begin
      anchor = scyc + 1;
      pv = 0; pd = 0; pstall = 0; mdl_done = 0;
    end else begin
      chk("busy_vs_done_exclusive", 32'(busy_o ^ init_done_o), 1);
      if (!cmd_valid_o) chk("idle_cmd_nop", 32'(cmd_o), 0);
      if (pstall) begin
        chk("hold_valid", 32'(cmd_valid_o), 1);
        chk("hold_cmd", 32'(cmd_o), 32'(pcmd));
      end
      if (cmd_valid_o && !pv) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cmd actual=%0d expected=none at %0t", cmd_o, $time);
        end else begin
          e = q.pop_front();
          chk("cmd_code", 32'(cmd_o), e.code);
          chk("cmd_gap", scyc - anchor, e.gap);
          chk("cmd_refcnt", 32'(ref_cnt_o), e.refc);
        end
      end
      if (init_done_o && !pd) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 expected=none at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("done_code", DONE_CODE, e.code);
          chk("done_gap", scyc - anchor, e.gap);
          chk("done_refcnt", 32'(ref_cnt_o), e.refc);
          mdl_done = 1;
        end
      end
      if (restart_i && mdl_done) begin
        anchor = scyc;
        mdl_done = 0;
      end
      if (cmd_valid_o && cmd_ack_i) anchor = scyc;
      pstall = cmd_valid_o && !cmd_ack_i;
      pcmd = cmd_o;
      pv = cmd_valid_o;
      pd = init_done_o;
    end
  end

  // Acknowledge driver: tied high, or random, with an optional forced stall on PRECHARGE.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (stall_left > 0 && cmd_valid_o && cmd_o == 3'd1) begin
        cmd_ack_i = 1'b0;
        stall_left--;
      end else if (ack_rand) begin
        cmd_ack_i = ($urandom_range(0, 2) != 0);
      end else begin
        cmd_ack_i = 1'b1;
      end
    end
  end

  task automatic wait_done(input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (init_done_o) begin
        checks++;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL done_timeout actual=0 expected=1 at %0t", $time);
  endtask

  task automatic wait_ack(input int unsigned code, input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cmd_valid_o && cmd_ack_i && 32'(cmd_o) == code) begin
        checks++;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL ack_timeout cmd=%0d actual=none expected=ack at %0t", code, $time);
  endtask

  task automatic pulse_restart();
    @(posedge clk);
    #2 restart_i = 1'b1;
    @(posedge clk);
    #2 restart_i = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(cmd_valid_o), 0);
    chk({tag, "_cmd"}, 32'(cmd_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 1);
    chk({tag, "_done"}, 32'(init_done_o), 0);
    chk({tag, "_refcnt"}, 32'(ref_cnt_o), 0);
  endtask

  initial begin
    // Run 1: power-up from reset, ack tied high
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    push_run(PWRUP);
    @(posedge clk);
    #2 rst = 1'b0;
    wait_done(PWRUP + 500);
    repeat (10) @(posedge clk);

    // Run 2: restart from DONE, PRE stalled 5 cycles, random acks, ignored restarts
    ack_rand = 1'b1;
    stall_left = 5;
    push_run(1);
    pulse_restart();
    @(negedge clk);
    chk("restart_done_low", 32'(init_done_o), 0);
    chk("restart_busy_high", 32'(busy_o), 1);
    wait_ack(2, 200);
    pulse_restart();
    wait_ack(3, 400);
    repeat (TMRD) @(posedge clk);
    #2 restart_i = 1'b1;
    @(posedge clk);
    #2 restart_i = 1'b0;
    wait_done(100);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("done_sticky", 32'(init_done_o), 1);

    // Run 3: restart, then reset during the 5th refresh wait
    push_run(1);
    pulse_restart();
    for (int i = 0; i < 5; i++) wait_ack(2, 300);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("midreset");
    q.delete();
    repeat (2) @(posedge clk);
    #2;
    push_run(PWRUP);
    rst = 1'b0;
    wait_done(PWRUP + 2000);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
